u12_pair_normalizer: RTL

- Downstream of the [1,2) uniform generator: accepts IEEE-754 single-precision samples x in [1,2) (sign 0, exponent 127, 23-bit LFSR mantissa).
- Maps each sample to u = 2.0 - x, so u is in (0,1]. Zero is excluded, which makes u safe for the log stage.
- Normalises u back to IEEE-754 and groups consecutive results into (u1,u2) pairs for the Box-Muller / Gaussian stage.
- Buffers pairs in a small FIFO with valid/ready backpressure.

---
 rtl/u12_pair_normalizer_pkg.sv | 13 +
 rtl/u12_pair_normalizer_lzc23.sv | 14 +
 rtl/u12_pair_normalizer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/u12_pair_normalizer_pkg.sv
// Shared constants and pair type for the uniform-to-Gaussian RNG path.
package heston_rng_pkg;

    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [8:0]  U12_TOP  = 9'b001111111;
    localparam int          EXP_BIAS = 127;

    typedef struct packed {
        logic [31:0] u1;
        logic [31:0] u2;
    } pair_t;

endpackage

// File: rtl/u12_pair_normalizer_lzc23.sv
// Combinational 23-bit leading-zero counter; all-zero input returns 23.
module lzc23 (
    input  logic [22:0] d_i,
    output logic [4:0]  lz_o
);

    always_comb begin
        lz_o = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (d_i[i]) lz_o = 5'(22 - i);
        end
    end

endmodule

// File: rtl/u12_pair_normalizer.sv
// Maps [1,2) floats to u = 2 - x in (0,1], renormalises and pairs them into a FWFT FIFO (U12_INPUT_CHECK_EN adds a sticky err).
// Pair visible 3 cycles after its second sample; in_ready is credit-gated so the FIFO can never overflow.
module u12_pair_normalizer
    import heston_rng_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_u1,
    output logic [31:0] out_u2,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = CW + 2;

    logic        accept;
    logic        v1_q, v2_q, hold_q;
    logic [23:0] r1_q;
    logic [31:0] res2_q, hold_dat_q;
    logic [4:0]  lz;
    logic [22:0] norm;
    logic [31:0] res_d;
    logic        push, pop;
    pair_t       mem_q [DEPTH];
    pair_t       last_q, head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [NW-1:0] need;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            r1_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept) r1_q <= 24'h80_0000 - {1'b0, in_data[22:0]};
        end
    end

    lzc23 u_lzc (
        .d_i  (r1_q[22:0]),
        .lz_o (lz)
    );

    // r1_q[23] is set only when the mantissa was zero, i.e. u is exactly 1.0
    always_comb begin
        norm  = r1_q[22:0] << lz;
        res_d = r1_q[23] ? FP_ONE
                         : {1'b0, 8'(EXP_BIAS - 1) - {3'b000, lz}, norm[21:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q       <= 1'b0;
            res2_q     <= '0;
            hold_q     <= 1'b0;
            hold_dat_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) res2_q <= res_d;
            if (v2_q) begin
                hold_q <= ~hold_q;
                if (!hold_q) hold_dat_q <= res2_q;
            end
        end
    end

    assign push = v2_q && hold_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{u1: hold_dat_q, u2: res2_q};
    end

    // last_q keeps the most recently popped pair so an empty FIFO holds its outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign head      = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign out_u1    = head.u1;
    assign out_u2    = head.u2;

    // Every in-flight sample and the held half-pair each reserve one slot half
    assign need     = {1'b0, count_q, 1'b0} + NW'(v1_q) + NW'(v2_q) + NW'(hold_q) + NW'(1);
    assign in_ready = (need <= NW'(2 * DEPTH));

`ifdef U12_INPUT_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (accept && (in_data[31:23] != U12_TOP)) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    logic unused_top;
    assign unused_top = ^in_data[31:23];
    assign err        = 1'b0;
`endif

endmodule
